// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store port: funct3 codes, FSM states,
// byte-lane type and access legality checks.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  typedef logic [1:0] lane_t;

  // Unsigned sizes exist only for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic we);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic f3_aligned(input logic [2:0] f3, input lane_t lane);
    logic ok;
    case (f3)
      F3_H, F3_HU: ok = ~lane[0];
      F3_W:        ok = (lane == 2'b00);
      default:     ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword from a bus read word and sign- or
// zero-extends it to 32 bits.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  lane_t       lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[8*lane +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Memory-stage load/store port: holds a bus request until ack, error or
// timeout, stalling the core meanwhile, and formats load data for writeback.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  output lsu_state_e  state_dbg
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_e    state_q, state_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [3:0]    bus_wstrb_q, bus_wstrb_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  lane_t         lane_q, lane_d;
  logic [2:0]    f3_q, f3_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          fault_q, fault_d;

  logic          access_ok;
  logic [3:0]    wstrb_new;
  logic [31:0]   wdata_new;
  logic [31:0]   load_data;

  load_align u_load_align (
    .word   (bus_rdata),
    .lane   (lane_q),
    .funct3 (f3_q),
    .data   (load_data)
  );

  assign access_ok = f3_legal(funct3, mem_we) & f3_aligned(funct3, addr[1:0]);

  // Lane strobes and store-data replication for the incoming instruction.
  always_comb begin
    wstrb_new = 4'b0000;
    wdata_new = 32'h0;
    if (mem_we) begin
      case (funct3)
        F3_B: begin
          wstrb_new = 4'b0001 << addr[1:0];
          wdata_new = {4{wdata[7:0]}};
        end
        F3_H: begin
          wstrb_new = 4'b0011 << addr[1:0];
          wdata_new = {2{wdata[15:0]}};
        end
        default: begin
          wstrb_new = 4'b1111;
          wdata_new = wdata;
        end
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;
    lane_d      = lane_q;
    f3_d        = f3_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    fault_d     = fault_q;
    stall       = 1'b0;
    fault       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_en) begin
          if (access_ok) begin
            stall       = 1'b1;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_we;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_wstrb_d = wstrb_new;
            bus_wdata_d = wdata_new;
            lane_d      = addr[1:0];
            f3_d        = funct3;
            cnt_d       = '0;
            state_d     = ST_REQ;
          end else begin
            fault = 1'b1;
          end
        end
      end
      ST_REQ: begin
        stall = 1'b1;
        // An ack on the final permitted cycle still completes normally.
        if (bus_ack) begin
          bus_req_d = 1'b0;
          fault_d   = bus_err;
          if (!bus_err && !bus_we_q) rdata_d = load_data;
          state_d   = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          bus_req_d = 1'b0;
          fault_d   = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        fault   = fault_q;
        fault_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wstrb_q <= 4'b0000;
      bus_wdata_q <= 32'h0;
      lane_q      <= 2'b00;
      f3_q        <= 3'b000;
      cnt_q       <= '0;
      rdata_q     <= 32'h0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
      lane_q      <= lane_d;
      f3_q        <= f3_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      fault_q     <= fault_d;
    end
  end

  assign rdata     = rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_wdata = bus_wdata_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: vector table, reset/ack/timeout corner sequences and
// randomized back-to-back traffic checked against a behavioural model.
module tb_lsu_mem_port;
  import lsu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        mem_en = 1'b0, mem_we = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        bus_ack = 1'b0, bus_err = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        sel_t = 1'b0;   // 1 routes traffic to the TIMEOUT=4 instance

  logic        a_stall, a_fault, a_bus_req, a_bus_we;
  logic [31:0] a_rdata, a_bus_addr, a_bus_wdata;
  logic [3:0]  a_bus_wstrb;
  lsu_state_e  a_state;
  logic        t_stall, t_fault, t_bus_req, t_bus_we;
  logic [31:0] t_rdata, t_bus_addr, t_bus_wdata;
  logic [3:0]  t_bus_wstrb;
  lsu_state_e  t_state;

  lsu_mem_port dut (
    .clk(clk), .rst_n(rst_n), .mem_en(mem_en & ~sel_t), .mem_we(mem_we),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(a_stall), .rdata(a_rdata),
    .fault(a_fault), .bus_req(a_bus_req), .bus_we(a_bus_we), .bus_addr(a_bus_addr),
    .bus_wstrb(a_bus_wstrb), .bus_wdata(a_bus_wdata), .bus_ack(bus_ack & ~sel_t),
    .bus_rdata(bus_rdata), .bus_err(bus_err), .state_dbg(a_state)
  );

  lsu_mem_port #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .mem_en(mem_en & sel_t), .mem_we(mem_we),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(t_stall), .rdata(t_rdata),
    .fault(t_fault), .bus_req(t_bus_req), .bus_we(t_bus_we), .bus_addr(t_bus_addr),
    .bus_wstrb(t_bus_wstrb), .bus_wdata(t_bus_wdata), .bus_ack(bus_ack & sel_t),
    .bus_rdata(bus_rdata), .bus_err(bus_err), .state_dbg(t_state)
  );

  logic        m_stall, m_fault, m_bus_req, m_bus_we;
  logic [31:0] m_rdata, m_bus_addr, m_bus_wdata;
  logic [3:0]  m_bus_wstrb;
  lsu_state_e  m_state;
  assign m_stall     = sel_t ? t_stall     : a_stall;
  assign m_fault     = sel_t ? t_fault     : a_fault;
  assign m_bus_req   = sel_t ? t_bus_req   : a_bus_req;
  assign m_bus_we    = sel_t ? t_bus_we    : a_bus_we;
  assign m_rdata     = sel_t ? t_rdata     : a_rdata;
  assign m_bus_addr  = sel_t ? t_bus_addr  : a_bus_addr;
  assign m_bus_wdata = sel_t ? t_bus_wdata : a_bus_wdata;
  assign m_bus_wstrb = sel_t ? t_bus_wstrb : a_bus_wstrb;
  assign m_state     = sel_t ? t_state     : a_state;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
    logic [31:0] v;
    v = word >> (8 * a[1:0]);
    if (nbytes(f3) == 1) return f3[2] ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
    if (nbytes(f3) == 2) return f3[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
    return word;
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
    int mask;
    mask = ((1 << nbytes(f3)) - 1) << a[1:0];
    return mask[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int nb;
    nb = nbytes(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
    return r;
  endfunction

  logic [31:0] exp_q[$];

  // ---------------- driver ----------------
  int          r_stalls, r_faults, r_req;
  logic [3:0]  r_strb;
  logic [31:0] r_badr, r_bwd, r_rdata;
  logic        r_bwe, r_stable;

  // Called in the low clock phase; returns in the low phase of the cycle after commit.
  // lat = REQ cycle on which ack is given (0 = never).
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int lat, input logic err,
                           input logic [31:0] rword);
    bit done;
    mem_en = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = wd;
    r_stalls = 0; r_faults = 0; r_req = 0; r_stable = 1'b1; done = 1'b0;
    r_strb = 4'h0; r_badr = 32'h0; r_bwd = 32'h0; r_bwe = 1'b0; r_rdata = 32'h0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
      if (m_bus_req) begin
        r_req++;
        if (r_req == 1) begin
          r_strb = m_bus_wstrb; r_badr = m_bus_addr; r_bwd = m_bus_wdata; r_bwe = m_bus_we;
        end else if ({m_bus_wstrb, m_bus_addr, m_bus_wdata, m_bus_we} !== {r_strb, r_badr, r_bwd, r_bwe}) begin
          r_stable = 1'b0;
        end
        if (r_req == lat) begin
          bus_ack = 1'b1; bus_err = err; bus_rdata = rword;
        end
      end
      #1;
      if (m_stall) r_stalls++;
      if (m_fault) r_faults++;
      if (!m_stall) begin
        done = 1'b1;
        r_rdata = m_rdata;
      end
      @(negedge clk);
    end
    mem_en = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
    check("access completed within budget", {31'h0, done}, 32'h1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    int          lat;
    logic        err;
    logic [31:0] rword;
    int          e_stalls;
    int          e_faults;
    int          e_req;
    logic [3:0]  e_strb;
    logic [31:0] e_bwd;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] cur;
    int          lat;
    int          op;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a, wd, rword, expd;

    //        we  f3      addr          wdata         lat err rword         stl flt req strb     bwd           rdata
    vecs[0]  = '{0, F3_B,  32'h0000_1003, 32'h0,        1, 0, 32'h80FF_0011, 2, 0, 1, 4'b0000, 32'h0,        32'hFFFF_FF80};
    vecs[1]  = '{0, F3_BU, 32'h0000_1003, 32'h0,        1, 0, 32'h80FF_0011, 2, 0, 1, 4'b0000, 32'h0,        32'h0000_0080};
    vecs[2]  = '{1, F3_H,  32'h0000_2002, 32'h1234_ABCD, 3, 0, 32'hFFFF_FFFF, 4, 0, 3, 4'b1100, 32'hABCD_ABCD, 32'h0000_0080};
    vecs[3]  = '{0, F3_W,  32'h0000_0006, 32'h0,        1, 0, 32'h0,         0, 1, 0, 4'b0000, 32'h0,        32'h0000_0080};
    vecs[4]  = '{0, F3_W,  32'h0000_0010, 32'h0,        2, 1, 32'hDEAD_BEEF, 3, 1, 2, 4'b0000, 32'h0,        32'h0000_0080};
    vecs[5]  = '{0, F3_H,  32'h0000_3002, 32'h0,        1, 0, 32'h7FFE_1234, 2, 0, 1, 4'b0000, 32'h0,        32'h0000_7FFE};
    vecs[6]  = '{0, F3_HU, 32'h0000_3002, 32'h0,        2, 0, 32'h8001_0000, 3, 0, 2, 4'b0000, 32'h0,        32'h0000_8001};
    vecs[7]  = '{1, F3_B,  32'h0000_4001, 32'h0000_00A5, 1, 0, 32'h0,         2, 0, 1, 4'b0010, 32'hA5A5_A5A5, 32'h0000_8001};
    vecs[8]  = '{1, F3_W,  32'h0000_5000, 32'hCAFE_F00D, 1, 0, 32'h0,         2, 0, 1, 4'b1111, 32'hCAFE_F00D, 32'h0000_8001};
    vecs[9]  = '{0, 3'b011, 32'h0000_0000, 32'h0,       1, 0, 32'h0,         0, 1, 0, 4'b0000, 32'h0,        32'h0000_8001};
    vecs[10] = '{1, F3_BU, 32'h0000_0000, 32'h0,        1, 0, 32'h0,         0, 1, 0, 4'b0000, 32'h0,        32'h0000_8001};
    vecs[11] = '{0, F3_W,  32'h0000_5000, 32'h0,        1, 0, 32'h1234_5678, 2, 0, 1, 4'b0000, 32'h0,        32'h1234_5678};
    vecs[12] = '{0, F3_B,  32'h0000_6000, 32'h0,        1, 0, 32'h0000_007F, 2, 0, 1, 4'b0000, 32'h0,        32'h0000_007F};
    vecs[13] = '{0, F3_H,  32'h0000_6001, 32'h0,        1, 0, 32'h0,         0, 1, 0, 4'b0000, 32'h0,        32'h0000_007F};

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset rdata", a_rdata, 32'h0);
    check("reset bus_req", {31'h0, a_bus_req}, 32'h0);
    check("reset bus_addr", a_bus_addr, 32'h0);
    check("reset bus_wstrb", {28'h0, a_bus_wstrb}, 32'h0);
    check("reset bus_wdata", a_bus_wdata, 32'h0);
    check("reset fault", {31'h0, a_fault}, 32'h0);
    check("reset state", 32'(a_state), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      do_access(vecs[i].we, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].lat, vecs[i].err, vecs[i].rword);
      check($sformatf("vec%0d stalls", i), r_stalls, vecs[i].e_stalls);
      check($sformatf("vec%0d faults", i), r_faults, vecs[i].e_faults);
      check($sformatf("vec%0d req cycles", i), r_req, vecs[i].e_req);
      check($sformatf("vec%0d rdata", i), r_rdata, vecs[i].e_rdata);
      if (vecs[i].e_req > 0) begin
        check($sformatf("vec%0d bus_addr", i), r_badr, {vecs[i].a[31:2], 2'b00});
        check($sformatf("vec%0d bus_wstrb", i), {28'h0, r_strb}, {28'h0, vecs[i].e_strb});
        check($sformatf("vec%0d bus_we", i), {31'h0, r_bwe}, {31'h0, vecs[i].we});
        check($sformatf("vec%0d bus stable", i), {31'h0, r_stable}, 32'h1);
        if (vecs[i].we) check($sformatf("vec%0d bus_wdata", i), r_bwd, vecs[i].e_bwd);
      end
    end

    // ack while idle is ignored
    bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    #1;
    check("idle ack fault", {31'h0, a_fault}, 32'h0);
    check("idle ack stall", {31'h0, a_stall}, 32'h0);
    @(negedge clk);
    bus_ack = 1'b0; bus_err = 1'b0;
    #1;
    check("idle ack state", 32'(a_state), 32'(ST_IDLE));
    check("idle ack rdata", a_rdata, 32'h0000_007F);
    check("idle ack fault after", {31'h0, a_fault}, 32'h0);
    @(negedge clk);

    // reset in the middle of a request
    mem_en = 1'b1; mem_we = 1'b0; funct3 = F3_W; addr = 32'h0000_0700;
    @(negedge clk);
    mem_en = 1'b0;
    @(negedge clk);
    #1;
    check("pre-reset bus_req", {31'h0, a_bus_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid-REQ reset bus_req", {31'h0, a_bus_req}, 32'h0);
    check("mid-REQ reset state", 32'(a_state), 32'(ST_IDLE));
    check("mid-REQ reset rdata", a_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_access(1'b0, F3_H, 32'h0, 32'h0, 1, 1'b0, 32'h0000_8001);
    check("post-reset LH rdata", r_rdata, 32'hFFFF_8001);
    check("post-reset LH stalls", r_stalls, 2);
    check("post-reset LH faults", r_faults, 0);

    // timeout instance (TIMEOUT=4)
    sel_t = 1'b1;
    do_access(1'b0, F3_W, 32'h40, 32'h0, 0, 1'b0, 32'h0);
    check("timeout req cycles", r_req, 4);
    check("timeout faults", r_faults, 1);
    check("timeout stalls", r_stalls, 5);
    check("timeout rdata", r_rdata, 32'h0);
    do_access(1'b0, F3_W, 32'h40, 32'h0, 4, 1'b0, 32'h55AA_1234);
    check("last-cycle ack faults", r_faults, 0);
    check("last-cycle ack rdata", r_rdata, 32'h55AA_1234);
    check("last-cycle ack req cycles", r_req, 4);
    do_access(1'b0, F3_W, 32'h44, 32'h0, 5, 1'b0, 32'h0BAD_0BAD);
    check("late ack faults", r_faults, 1);
    check("late ack rdata", r_rdata, 32'h55AA_1234);
    sel_t = 1'b0;

    // randomized back-to-back LW / SW / LHU
    cur = 32'hFFFF_8001;
    for (int i = 0; i < 24; i++) begin
      op  = $urandom_range(0, 2);
      lat = $urandom_range(1, 10);
      we  = (op == 1);
      f3  = (op == 2) ? F3_HU : F3_W;
      a   = $urandom;
      a   = (op == 2) ? {a[31:1], 1'b0} : {a[31:2], 2'b00};
      wd  = $urandom;
      rword = $urandom;
      exp_q.push_back(we ? cur : model_load(f3, a, rword));
      do_access(we, f3, a, wd, lat, 1'b0, rword);
      expd = exp_q.pop_front();
      check($sformatf("rnd%0d rdata", i), r_rdata, expd);
      cur = expd;
      check($sformatf("rnd%0d stalls", i), r_stalls, lat + 1);
      check($sformatf("rnd%0d req cycles", i), r_req, lat);
      check($sformatf("rnd%0d faults", i), r_faults, 0);
      check($sformatf("rnd%0d bus_addr", i), r_badr, {a[31:2], 2'b00});
      check($sformatf("rnd%0d bus_wstrb", i), {28'h0, r_strb},
            {28'h0, (we ? model_strb(f3, a) : 4'b0000)});
      check($sformatf("rnd%0d bus stable", i), {31'h0, r_stable}, 32'h1);
      if (we) check($sformatf("rnd%0d bus_wdata", i), r_bwd, model_wdata(f3, wd));
    end

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store port between the single-cycle core's memory stage and a variable-latency data-memory bus. Turns a core load/store into a held bus request with byte strobes. Formats returned read data (lane select, sign/zero extension) into the `memory_data` value consumed by the writeback result-select mux. Stalls the core until the access completes, times out, or errors.

## Interface
- `TIMEOUT`, default 255: max cycles in REQ without `bus_ack` before the access is aborted as a fault (≥1).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mem_en`  in  1  memory instruction present this cycle.
- `mem_we`  in  1  1 = store, 0 = load.
- `funct3`  in  3  RISC-V size/sign field.
- `addr`  in  32  byte address (ALU result).
- `wdata`  in  32  store data (rs2).
- `stall`  out  1  hold PC and pipeline state this cycle.
- `rdata`  out  32  formatted load data (`memory_data` to writeback).
- `fault`  out  1  one-cycle pulse: misaligned, illegal funct3, bus error, or timeout.
- `bus_req`  out  1  request valid; held until ack.
- `bus_we`  out  1  write request.
- `bus_addr`  out  32  word-aligned address (`addr[31:2],2'b00`).
- `bus_wstrb`  out  4  byte enables.
- `bus_wdata`  out  32  store data replicated to lanes.
- `bus_ack`  in  1  request complete this cycle.
- `bus_rdata`  in  32  read word, valid with `bus_ack`.
- `bus_err`  in  1  access failed, valid with `bus_ack`.

## Operation
- funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only). Any other code, or BU/HU with `mem_we`=1, is illegal.
- Misaligned: H/HU with `addr[0]`=1; W with `addr[1:0]`≠0.
- FSM IDLE/REQ/DONE:
  - IDLE: `mem_en` with legal, aligned access → latch `bus_we/bus_addr/bus_wstrb/bus_wdata`, `lane=addr[1:0]`, funct3 → REQ.
  - IDLE: `mem_en` with illegal or misaligned access → no bus access, `fault`=1 this cycle, `stall`=0, stay IDLE.
  - REQ: `bus_ack`=1 → capture formatted `bus_rdata` into `rdata` (loads only), `fault` next cycle if `bus_err` → DONE.
  - REQ: counter reaches `TIMEOUT` without ack → drop `bus_req`, set fault → DONE.
  - DONE: `stall`=0, `rdata` and `fault` valid for the core's commit → IDLE unconditionally.
- `stall` = (IDLE & `mem_en` & legal & aligned) | REQ. Combinational.
- Strobes/data: B → `wstrb=1<<lane`, `wdata={4{wdata[7:0]}}`. H → `wstrb=4'b0011<<lane`, `{2{wdata[15:0]}}`. W → `4'b1111`, `wdata`. Loads drive `wstrb=0`.
- Load format: B/BU select `bus_rdata[8*lane+:8]`. H/HU select `[16*lane[1]+:16]`. B/H sign-extend; BU/HU zero-extend.
- `rdata` holds its value until the next completed load. Stores and faults leave it unchanged.
- On error or timeout, `rdata` is unchanged.

## Timing
- Reset (async, any state): state IDLE, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wstrb`=0, `bus_wdata`=0, `rdata`=0, `fault`=0, counter 0. Takes effect mid-REQ immediately; the outstanding bus transaction is abandoned.
- `bus_req` rises the cycle after acceptance. `bus_we/addr/wstrb/wdata` are stable while `bus_req`=1.
- `bus_req` falls the cycle after `bus_ack`.
- Minimum access with ack in the first REQ cycle:
  - cycle 0: IDLE, stall.
  - cycle 1: REQ, stall.
  - cycle 2: DONE, commit.
  - Core sees 2 stall cycles; N-cycle ack adds N−1.
- `bus_ack` outside REQ is ignored.
- Back-to-back memory instructions: each incurs the full IDLE→REQ→DONE sequence; DONE never accepts.
- Timeout counter: cleared on entry to REQ; fault when count = `TIMEOUT`−1 with no ack. Ack on that same cycle wins (normal completion).

## Structure
- Package `lsu_pkg`: funct3 constants (`F3_B/H/W/BU/HU`), state enum, `lane_t` (2-bit).
- Sub-module `load_align`: combinational lane select + extension (`bus_rdata`, lane, funct3 → 32-bit). Reused by any future cache fill path.
- Top: FSM, request registers, timeout counter, strobe/replication logic.

## Test plan
- LB at `addr=0x1003`, `bus_rdata=0x80FF_0011`, ack in the first REQ cycle → `bus_addr=0x1000`, `wstrb=0`, 2 stall cycles, `rdata=0xFFFF_FF80`. Repeat as LBU → `0x0000_0080`.
- SH at `addr=0x2002`, `wdata=0x1234_ABCD`, ack after 3 cycles → `bus_wstrb=4'b1100`, `bus_wdata=0xABCD_ABCD`, 4 stall cycles, `rdata` unchanged.
- LW at `addr=0x0006` → `fault` pulses once, `stall`=0, `bus_req` never rises.
- LW with `bus_err=1` on ack → `fault` in DONE, `rdata` unchanged. With `TIMEOUT=4` and no ack → `bus_req` high exactly 4 cycles, then `fault`.
- Assert `rst_n`=0 during REQ → `bus_req`=0 immediately, state IDLE. A fresh LH at `0x0` after release completes normally (`bus_rdata=0x0000_8001` → `rdata=0xFFFF_8001`).
- Back-to-back LW, SW, LHU with random ack latencies 1–10 → each completes in order, one DONE per instruction, strobes and data match a reference model.
